// File: rtl/slow_clk_gen.sv
// slow_clk_gen: parametrised counter-based clock-enable / square-wave generator.
// Optional macro SLOWCLK_PHASE_ALIGN_EN adds the align input for phase restart.
module slow_clk_gen #(
    parameter int NUM_CH = 3,
    parameter int CNT_W = 16,
    parameter logic [NUM_CH*CNT_W-1:0] DIV_INIT = {16'd4, 16'd16, 16'd16},
    parameter bit CASCADE = 1'b1,
    localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              sysclk,
    input  logic              rst,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [CH_W-1:0]   cfg_ch,
    input  logic [CNT_W-1:0]  cfg_div,
    output logic              cfg_err,
    output logic [NUM_CH-1:0] ce,
    output logic [NUM_CH-1:0] clk_out,
    output logic              locked
`ifdef SLOWCLK_PHASE_ALIGN_EN
    ,
    input  logic              align
`endif
);

    typedef enum logic [1:0] {
        ACQ,
        LOCK,
        PEND,
        SETTLE
    } state_t;

    localparam logic [CNT_W-1:0] ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] TWO = CNT_W'(2);
    localparam logic [CH_W:0] CH_LIM = (CH_W + 1)'(NUM_CH);

    state_t state;

    logic [CNT_W-1:0] cnt [NUM_CH];
    logic [CNT_W-1:0] div [NUM_CH];
    logic [CNT_W-1:0] cnt_nxt [NUM_CH];

    logic [NUM_CH-1:0] match;
    logic [NUM_CH-1:0] tick;
    logic [NUM_CH-1:0] wrap;
    logic [NUM_CH-1:0] seen;
    logic [NUM_CH-1:0] lvl;

    logic [CH_W-1:0]  p_ch;
    logic [CNT_W-1:0] p_div;

    logic align_w;
    logic illegal;
    logic take;
    logic p_wrap;

`ifdef SLOWCLK_PHASE_ALIGN_EN
    assign align_w = align;
`else
    assign align_w = 1'b0;
`endif

    assign illegal = (cfg_div < TWO) || ({1'b0, cfg_ch} >= CH_LIM);
    assign take    = cfg_valid & cfg_ready & ~illegal;
    assign p_wrap  = wrap[p_ch];

    // run carries the upstream wrap so the cascade has no self-loop
    always_comb begin
        logic run;
        run = 1'b1;
        for (int k = 0; k < NUM_CH; k++) begin
            match[k] = (cnt[k] == div[k] - ONE);
            tick[k] = (CASCADE && k > 0) ? run : 1'b1;
            wrap[k] = tick[k] & match[k];
            run = wrap[k];
            if (wrap[k]) begin
                cnt_nxt[k] = '0;
            end else if (tick[k]) begin
                cnt_nxt[k] = cnt[k] + ONE;
            end else begin
                cnt_nxt[k] = cnt[k];
            end
            lvl[k] = cnt_nxt[k] >= (div[k] - (div[k] >> 1));
        end
    end

    always_ff @(posedge sysclk) begin
        if (rst) begin
            for (int k = 0; k < NUM_CH; k++) begin
                cnt[k] <= '0;
                div[k] <= DIV_INIT[k*CNT_W +: CNT_W];
            end
            ce      <= '0;
            clk_out <= '0;
            seen    <= '0;
        end else if (align_w) begin
            for (int k = 0; k < NUM_CH; k++) begin
                cnt[k] <= '0;
            end
            if (state == PEND) begin
                div[p_ch] <= p_div;
            end
            if (take) begin
                div[cfg_ch] <= cfg_div;
            end
            ce      <= '0;
            clk_out <= '0;
            seen    <= '0;
        end else begin
            for (int k = 0; k < NUM_CH; k++) begin
                cnt[k] <= cnt_nxt[k];
            end
            if (state == PEND && p_wrap) begin
                div[p_ch] <= p_div;
            end
            ce      <= wrap;
            clk_out <= lvl;
            seen    <= seen | wrap;
        end
    end

    always_ff @(posedge sysclk) begin
        if (rst) begin
            state     <= ACQ;
            locked    <= 1'b0;
            cfg_ready <= 1'b1;
            cfg_err   <= 1'b0;
            p_ch      <= '0;
            p_div     <= '0;
        end else begin
            cfg_err <= cfg_valid & cfg_ready & illegal;
            if (align_w) begin
                state     <= ACQ;
                locked    <= 1'b0;
                cfg_ready <= 1'b1;
            end else begin
                unique case (state)
                    ACQ, LOCK: begin
                        if (take) begin
                            state     <= PEND;
                            locked    <= 1'b0;
                            cfg_ready <= 1'b0;
                            p_ch      <= cfg_ch;
                            p_div     <= cfg_div;
                        end else if (&seen) begin
                            state  <= LOCK;
                            locked <= 1'b1;
                        end
                    end
                    PEND: begin
                        if (p_wrap) begin
                            state <= SETTLE;
                        end
                    end
                    SETTLE: begin
                        if (p_wrap) begin
                            cfg_ready <= 1'b1;
                            if (&(seen | wrap)) begin
                                state  <= LOCK;
                                locked <= 1'b1;
                            end else begin
                                state <= ACQ;
                            end
                        end
                    end
                    default: begin
                        state <= ACQ;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_slow_clk_gen.sv
// tb_slow_clk_gen: directed, table and random checks of slow_clk_gen.
// Cascaded default DUT is tracked by a ticks-remaining reference model.
module tb_slow_clk_gen;

    logic        clk;
    logic        rst;
    logic        cfg_valid;
    logic        cfg_ready;
    logic [1:0]  cfg_ch;
    logic [15:0] cfg_div;
    logic        cfg_err;
    logic [2:0]  ce;
    logic [2:0]  clk_out;
    logic        locked;
    logic        align;

    logic        b_valid;
    logic        b_ready;
    logic [1:0]  b_ch;
    logic [15:0] b_div;
    logic        b_err;
    logic [2:0]  b_ce;
    logic [2:0]  b_clk_out;
    logic        b_locked;

    int n_cmp;
    int n_bad;

    int       m_div [3];
    int       m_rem [3];
    bit [2:0] m_seen;
    bit [2:0] m_ce;
    bit [2:0] m_clk;
    int       m_phase;
    int       m_pch;
    int       m_pdiv;
    bit       m_ready;
    bit       m_locked;
    bit       m_err;

    typedef struct {
        logic        v;
        logic [1:0]  ch;
        logic [15:0] dv;
        logic        err;
    } vec_t;

    vec_t tbl [6];

    slow_clk_gen dut (
        .sysclk   (clk),
        .rst      (rst),
        .cfg_valid(cfg_valid),
        .cfg_ready(cfg_ready),
        .cfg_ch   (cfg_ch),
        .cfg_div  (cfg_div),
        .cfg_err  (cfg_err),
        .ce       (ce),
        .clk_out  (clk_out),
        .locked   (locked)
`ifdef SLOWCLK_PHASE_ALIGN_EN
        ,
        .align    (align)
`endif
    );

    slow_clk_gen #(.CASCADE(1'b0)) dut_b (
        .sysclk   (clk),
        .rst      (rst),
        .cfg_valid(b_valid),
        .cfg_ready(b_ready),
        .cfg_ch   (b_ch),
        .cfg_div  (b_div),
        .cfg_err  (b_err),
        .ce       (b_ce),
        .clk_out  (b_clk_out),
        .locked   (b_locked)
`ifdef SLOWCLK_PHASE_ALIGN_EN
        ,
        .align    (align)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm,
                       input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    // Each channel counts ticks remaining to its next wrap.
    task automatic model_step();
        bit [2:0] w;
        bit [2:0] tk;
        bit run;
        bit ill;
        bit acc;
        bit all_prev;
        if (rst) begin
            m_div = '{16, 16, 4};
            for (int k = 0; k < 3; k++) m_rem[k] = m_div[k] - 1;
            m_seen = '0;
            m_ce = '0;
            m_clk = '0;
            m_phase = 0;
            m_ready = 1'b1;
            m_locked = 1'b0;
            m_err = 1'b0;
            return;
        end
        ill = (cfg_div < 16'd2) || (cfg_ch == 2'd3);
        m_err = cfg_valid && m_ready && ill;
        acc = cfg_valid && m_ready && !ill;
        run = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tk[k] = run;
            w[k] = run && (m_rem[k] == 0);
            run = w[k];
        end
        all_prev = &m_seen;
        if (align) begin
            if (m_phase == 1) m_div[m_pch] = m_pdiv;
            if (acc) m_div[cfg_ch] = int'(cfg_div);
            for (int k = 0; k < 3; k++) m_rem[k] = m_div[k] - 1;
            m_seen = '0;
            m_ce = '0;
            m_clk = '0;
            m_phase = 0;
            m_ready = 1'b1;
            m_locked = 1'b0;
            return;
        end
        for (int k = 0; k < 3; k++) begin
            if (w[k]) begin
                if (m_phase == 1 && m_pch == k) m_div[k] = m_pdiv;
                m_rem[k] = m_div[k] - 1;
                m_seen[k] = 1'b1;
            end else if (tk[k]) begin
                m_rem[k] = m_rem[k] - 1;
            end
            m_clk[k] = m_rem[k] < m_div[k] / 2;
            m_ce[k] = w[k];
        end
        case (m_phase)
            0: begin
                if (acc) begin
                    m_phase = 1;
                    m_pch = int'(cfg_ch);
                    m_pdiv = int'(cfg_div);
                    m_ready = 1'b0;
                    m_locked = 1'b0;
                end else if (all_prev) begin
                    m_locked = 1'b1;
                end
            end
            1: if (w[m_pch]) m_phase = 2;
            default: begin
                if (w[m_pch]) begin
                    m_phase = 0;
                    m_ready = 1'b1;
                    m_locked = &m_seen;
                end
            end
        endcase
    endtask

    task automatic cyc();
        @(posedge clk);
        model_step();
        @(negedge clk);
        chk("model", {23'd0, ce, clk_out, locked, cfg_ready, cfg_err},
            {23'd0, m_ce, m_clk, m_locked, m_ready, m_err});
    endtask

    task automatic wait_ce(input bit use_b, input int ch,
                           input int lim, output int t);
        t = -1;
        for (int i = 1; i <= lim; i++) begin
            cyc();
            if ((use_b ? b_ce[ch] : ce[ch]) === 1'b1) begin
                t = i;
                break;
            end
        end
    endtask

    task automatic wait_ready(input int lim, output int ok);
        ok = 0;
        for (int i = 0; i < lim; i++) begin
            cyc();
            if (cfg_ready === 1'b1) begin
                ok = 1;
                break;
            end
        end
    endtask

    task automatic req(input logic [1:0] ch, input logic [15:0] dv);
        cfg_valid = 1'b1;
        cfg_ch = ch;
        cfg_div = dv;
        cyc();
        cfg_valid = 1'b0;
    endtask

    initial begin
        int f0, s0, f1, f2, lk, hi, r0, bf1, bf2, t, a, ok;
        logic [2:0] ce_at, bce_at;
        logic [9:0] pc, pe;
        logic [1:0] rl;

        tbl[0] = '{1'b1, 2'd0, 16'd1, 1'b1};
        tbl[1] = '{1'b1, 2'd3, 16'd5, 1'b1};
        tbl[2] = '{1'b1, 2'd1, 16'd0, 1'b1};
        tbl[3] = '{1'b0, 2'd3, 16'd0, 1'b0};
        tbl[4] = '{1'b1, 2'd3, 16'd1, 1'b1};
        tbl[5] = '{1'b1, 2'd2, 16'd1, 1'b1};

        n_cmp = 0;
        n_bad = 0;
        rst = 1'b1;
        cfg_valid = 1'b0;
        cfg_ch = '0;
        cfg_div = '0;
        align = 1'b0;
        b_valid = 1'b0;
        b_ch = '0;
        b_div = '0;

        repeat (3) cyc();
        chk("reset", {23'd0, ce, clk_out, locked, cfg_ready, cfg_err},
            32'b0_0000_0010);

        rst = 1'b0;
        f0 = -1; s0 = -1; f1 = -1; f2 = -1; lk = -1;
        hi = 0; r0 = -1; bf1 = -1; bf2 = -1;
        ce_at = '0; bce_at = '0;
        for (int i = 1; i <= 1030; i++) begin
            cyc();
            if (ce[0] && f0 >= 0 && s0 < 0) s0 = i;
            if (ce[0] && f0 < 0) f0 = i;
            if (ce[1] && f1 < 0) f1 = i;
            if (ce[2] && f2 < 0) f2 = i;
            if (locked && lk < 0) lk = i;
            if (i <= 16 && clk_out[0]) hi++;
            if (clk_out[0] && r0 < 0) r0 = i;
            if (b_ce[1] && bf1 < 0) bf1 = i;
            if (b_ce[2] && bf2 < 0) bf2 = i;
            if (i == 1024) ce_at = ce;
            if (i == 16) bce_at = b_ce;
        end
        chk("ce0_first", f0, 16);
        chk("ce0_second", s0, 32);
        chk("ce1_first", f1, 256);
        chk("ce2_first", f2, 1024);
        chk("ce_coincide", {29'd0, ce_at}, 32'd7);
        chk("lock_rise", lk, 1025);
        chk("clk0_high", hi, 8);
        chk("clk0_rise", r0, 8);
        chk("b_ce1_first", bf1, 16);
        chk("b_ce2_first", bf2, 4);
        chk("b_ce_at16", {29'd0, bce_at}, 32'd7);

        foreach (tbl[i]) begin
            cfg_valid = tbl[i].v;
            cfg_ch = tbl[i].ch;
            cfg_div = tbl[i].dv;
            cyc();
            cfg_valid = 1'b0;
            chk("tbl_err", {31'd0, cfg_err}, {31'd0, tbl[i].err});
            cyc();
            chk("tbl_after", {29'd0, cfg_err, locked, cfg_ready}, 32'd3);
        end

        req(2'd0, 16'd5);
        chk("div5_busy", {30'd0, cfg_ready, locked}, 32'd0);
        wait_ce(1'b0, 0, 40, t);
        chk("div5_pend_wrap", {31'd0, t > 0}, 32'd1);
        for (int i = 0; i < 10; i++) begin
            cyc();
            pc[i] = clk_out[0];
            pe[i] = ce[0];
            if (i == 4) rl = {cfg_ready, locked};
        end
        chk("div5_clk", {22'd0, pc}, {22'd0, 10'b0110001100});
        chk("div5_ce", {22'd0, pe}, {22'd0, 10'b1000010000});
        chk("div5_relock", {30'd0, rl}, 32'd3);

        req(2'd0, 16'd16);
        wait_ready(100, ok);
        chk("restore_ch0", ok, 1);

        req(2'd1, 16'd32);
        chk("div32_busy", {30'd0, cfg_ready, locked}, 32'd0);
        wait_ce(1'b0, 1, 300, t);
        chk("div32_pend_wrap", {31'd0, t > 0}, 32'd1);
        req(2'd2, 16'd2);
        chk("busy_ignored", {30'd0, cfg_err, cfg_ready}, 32'd0);
        wait_ce(1'b0, 1, 600, a);
        chk("ce1_period512", a + 1, 512);
        chk("div32_relock", {30'd0, cfg_ready, locked}, 32'd3);

        req(2'd1, 16'd32);
        repeat (3) cyc();
        chk("pend_busy", {31'd0, cfg_ready}, 32'd0);
        rst = 1'b1;
        cyc();
        chk("rst_in_pend", {23'd0, ce, clk_out, locked, cfg_ready, cfg_err},
            32'b0_0000_0010);
        rst = 1'b0;
        wait_ce(1'b0, 1, 300, t);
        chk("ce1_after_rst", t, 256);

`ifdef SLOWCLK_PHASE_ALIGN_EN
        repeat (5) cyc();
        align = 1'b1;
        cyc();
        align = 1'b0;
        chk("align_b", {25'd0, b_ce, b_clk_out, b_locked}, 32'd0);
        chk("align_a_lock", {31'd0, locked}, 32'd0);
        wait_ce(1'b1, 0, 40, t);
        chk("align_b_ce0", t, 16);
`endif

        for (int i = 0; i < 4000; i++) begin
            cfg_valid = ($urandom_range(0, 7) == 0);
            cfg_ch = 2'($urandom_range(0, 3));
            cfg_div = 16'($urandom_range(0, 7));
            rst = ($urandom_range(0, 1999) == 0);
`ifdef SLOWCLK_PHASE_ALIGN_EN
            align = ($urandom_range(0, 499) == 0);
`endif
            cyc();
        end
        cfg_valid = 1'b0;
        rst = 1'b0;
        align = 1'b0;
        cyc();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
